// File: rtl/intellight_pkg.sv
// intellight_pkg: shared widths, write-back latency and FSM
// encoding for the Q-learning step controller.
package intellight_pkg;

  localparam int L_WIDTH = 4;
  localparam int S_WIDTH = 2 * L_WIDTH;
  localparam int A_WIDTH = L_WIDTH / 2 + 2;
  localparam int WB_LAT  = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/inflight_tracker.sv
// inflight_tracker: carries issued {valid, S} down to write-back
// and flags read-after-write conflicts against a new state.
module inflight_tracker #(
  parameter int S_WIDTH = 8,
  parameter int DEPTH   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [S_WIDTH-1:0] in_s,
  input  logic               cmp_valid,
  input  logic [S_WIDTH-1:0] cmp_s,
  output logic               wen,
  output logic               hazard,
  output logic               pending
);

  logic [DEPTH-1:0]   vld;
  logic [S_WIDTH-1:0] sq [DEPTH];

  // advance every issued step one stage toward write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) sq[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      sq[0]  <= in_s;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        sq[i]  <= sq[i-1];
      end
    end
  end

  // the issuing step counts as in flight; the writing
  // stage conflicts but is no longer pending afterwards
  always_comb begin
    hazard  = in_valid && (in_s == cmp_s);
    pending = in_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (sq[i] == cmp_s)) hazard = 1'b1;
      if (vld[i] && (i < DEPTH - 1)) pending = 1'b1;
    end
    hazard = hazard && cmp_valid;
  end

  assign wen = vld[DEPTH-1];

endmodule

// File: rtl/qlearn_step_ctrl.sv
// qlearn_step_ctrl: sequences training steps and episodes,
// issuing (S, A) and holding off read-after-write hazards.
module qlearn_step_ctrl #(
  parameter int L_WIDTH   = intellight_pkg::L_WIDTH,
  parameter int WB_LAT    = intellight_pkg::WB_LAT,
  parameter int CNT_WIDTH = 16,
  localparam int SW       = 2 * L_WIDTH,
  localparam int AW       = L_WIDTH / 2 + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] max_step,
  input  logic [CNT_WIDTH-1:0] max_episode,
  input  logic                 step_valid,
  input  logic [SW-1:0]        step_S,
  input  logic [AW-1:0]        step_A,
  output logic                 step_ready,
  output logic [SW-1:0]        S,
  output logic [AW-1:0]        A,
  output logic                 issue,
  output logic                 wen,
  output logic                 hazard_stall,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] step_cnt,
  output logic [CNT_WIDTH-1:0] episode_cnt
);
  import intellight_pkg::*;

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic               aborted;
  logic               hazard;
  logic               pending;
  logic               accept;
  logic               go;
  logic               drain_end;
  logic               again;
  logic [CNT_WIDTH:0] ep_inc;

  inflight_tracker #(
    .S_WIDTH (SW),
    .DEPTH   (WB_LAT)
  ) u_trk (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_s      (S),
    .cmp_valid (step_valid),
    .cmp_s     (step_S),
    .wen       (wen),
    .hazard    (hazard),
    .pending   (pending)
  );

  assign ep_inc = {1'b0, episode_cnt}
                + (CNT_WIDTH+1)'(1);
  assign again = (ep_inc < {1'b0, max_episode})
              && !aborted && !abort;
  assign go = (state == ST_IDLE) && start;
  assign drain_end = (state == ST_DRAIN) && !pending;

  assign step_ready = (state == ST_RUN) && !hazard
                   && (step_cnt < max_step) && !abort;
  assign accept = step_valid && step_ready;
  assign hazard_stall = hazard && (state == ST_RUN);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == ST_IDLE: begin
        if (start)
          state_nx = (max_step != '0 && max_episode != '0)
                   ? ST_RUN : ST_DONE;
      end
      state == ST_RUN: begin
        if (abort || step_cnt >= max_step)
          state_nx = ST_DRAIN;
      end
      state == ST_DRAIN: begin
        if (!pending)
          state_nx = again ? ST_RUN : ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM, sticky abort and progress counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      aborted     <= 1'b0;
      step_cnt    <= '0;
      episode_cnt <= '0;
    end else begin
      state <= state_nx;
      if (go) aborted <= 1'b0;
      else if (abort && (state == ST_RUN ||
                         state == ST_DRAIN))
        aborted <= 1'b1;
      if (go) step_cnt <= '0;
      else if (drain_end && again) step_cnt <= '0;
      else if (accept)
        step_cnt <= step_cnt + CNT_WIDTH'(1);
      if (go) episode_cnt <= '0;
      else if (drain_end)
        episode_cnt <= ep_inc[CNT_WIDTH-1:0];
    end
  end

  // registered step toward the memory interface
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue <= 1'b0;
      S     <= '0;
      A     <= '0;
    end else begin
      issue <= accept;
      S     <= accept ? step_S : '0;
      A     <= accept ? step_A : '0;
    end
  end

endmodule

// File: doc/qlearn_step_ctrl.md
QLEARN_STEP_CTRL -- requirements
Module: qlearn_step_ctrl

Interface
REQ-001 Parameter L_WIDTH, default 4: level width; S_WIDTH = 2*L_WIDTH, A_WIDTH = L_WIDTH/2 + 2.
REQ-002 Parameter WB_LAT, default 5: cycles from step issue to Q-table write-back.
REQ-003 Parameter CNT_WIDTH, default 16: width of step and episode counters and limits.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse that begins a training run.
REQ-008 abort  in  1  synchronous request to end the run early.
REQ-009 max_step  in  CNT_WIDTH  steps per episode.
REQ-010 max_episode  in  CNT_WIDTH  episodes per run.
REQ-011 step_valid  in  1  upstream step (state, action) available.
REQ-012 step_S  in  S_WIDTH  current state.
REQ-013 step_A  in  A_WIDTH  chosen action: {road[1:0], duration}.
REQ-014 step_ready  out  1  controller accepts the step this cycle.
REQ-015 S  out  S_WIDTH  state to memory interface, registered.
REQ-016 A  out  A_WIDTH  action to memory interface, registered.
REQ-017 issue  out  1  S/A carry a valid step this cycle.
REQ-018 wen  out  1  write-back enable to memory interface.
REQ-019 hazard_stall  out  1  step held off by a read-after-write conflict.
REQ-020 busy  out  1  FSM not IDLE.
REQ-021 done  out  1  one-cycle pulse at run completion.
REQ-022 step_cnt, episode_cnt  out  CNT_WIDTH each  progress counters.

Function
REQ-023 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start when max_step!=0 and max_episode!=0.
- IDLE->DONE on start when either limit is 0.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Step accept SHALL be step_valid & step_ready, with step_ready = (state==RUN) & !hazard & (step_cnt < max_step) & !abort.
REQ-026 On accept, the block SHALL register S<=step_S and A<=step_A, set issue=1 for exactly the next cycle, and increment step_cnt.
- When not issuing, S and A SHALL be driven to 0.
REQ-027 An in-flight tracker SHALL shift {valid, S} for WB_LAT stages; wen SHALL equal the valid bit of the last stage.
- wen is high exactly WB_LAT cycles after the issue cycle, one cycle per accepted step, back-to-back allowed.
REQ-028 hazard SHALL be 1 when step_valid and step_S equals the S of any valid in-flight stage, including the stage writing this cycle; hazard_stall = hazard & (state==RUN).
REQ-029 RUN->DRAIN when step_cnt reaches max_step, or when abort is sampled high.
REQ-030 DRAIN SHALL wait until all in-flight valid bits are 0; on that cycle episode_cnt increments.
- DRAIN->RUN with step_cnt cleared when episode_cnt+1 < max_episode and no abort occurred.
- Otherwise DRAIN->DONE.
REQ-031 DONE SHALL assert done for one cycle, then go to IDLE; counters hold their final values until the next accepted start.
REQ-032 On the start-accepted cycle, step_cnt and episode_cnt SHALL clear.
REQ-033 Counters SHALL not wrap; accept is blocked at max_step.
REQ-034 abort SHALL be ignored in IDLE and DONE; in DRAIN it suppresses the return to RUN.

Reset
REQ-035 On rst low, all outputs and state SHALL clear to 0 asynchronously: FSM=IDLE, tracker valids=0, wen=0, issue=0, done=0, counters=0.
REQ-036 A reset mid-run SHALL discard in-flight writes; no wen after deassertion until new issues occur.

Structure
REQ-037 Package intellight_pkg SHALL hold L_WIDTH, S_WIDTH, A_WIDTH, WB_LAT and the FSM state encoding.
REQ-038 The valid/S shift register and hazard compare SHALL be one sub-module, inflight_tracker.

Verification
REQ-039 The bench SHALL cover these scenarios:
- max_step=3, max_episode=1, steps S=1,2,3 back-to-back -> issue on 3 consecutive cycles, wen pulses 5 cycles after each, done 1 cycle after the last wen, episode_cnt=1.
- S=7 issued, next step S=7 -> step_ready=0 and hazard_stall=1 for 5 cycles, then accepted on the cycle after the first write.
- max_step=2, max_episode=3 -> 6 issues, 6 wen, episode_cnt=3, single done pulse.
- abort in RUN after 1 of 4 steps -> no further accepts, 1 wen, then done; episode_cnt=1.
- start with max_episode=0 -> done next-next cycle, no issue, no wen.
- rst low 2 cycles after an issue -> wen never asserts, busy=0, counters=0.
